star_spawner: RTL and testbench
===============================

STAR_SPAWNER -- requirements
Module: star_spawner

Interface
REQ-001 Parameter COOLDOWN_FRAMES, default 10'd300, counted frames between a star leaving play and the next spawn.
REQ-002 Parameter LIFETIME_FRAMES, default 10'd600, counted frames an uncollected star stays spawned.
REQ-003 Parameter BOOST_FRAMES, default 10'd480, counted frames boost_active stays high after collection.
REQ-004 Parameter LFSR_SEED, default 16'hACE1, LFSR reset value; a seed of 0 SHALL load 16'h0001 instead.
REQ-005 CLK  input  1  single system clock; all state on its rising edge.
REQ-006 RESET_N  input  1  reset, asynchronous, active-low.
REQ-007 frame_tick  input  1  one-CLK-cycle pulse per video frame, synchronous to CLK.
REQ-008 Pause  input  1  high freezes all frame counters.
REQ-009 game_active  input  1  high while a round is in play.
REQ-010 StarBoost  input  1  collection indication returned by the star sprite.
REQ-011 spawned  output  1  star present in play (drives sprite spawned).
REQ-012 X_Start, Y_Start  output  10 each  spawn position.
REQ-013 X_Step, Y_Step  output  10 each  per-frame motion step.
REQ-014 boost_active  output  1  player invincibility window.
REQ-015 spawn_count  output  8  stars spawned this round, wraps 255->0.

Function
REQ-016 FSM states: IDLE, COOLDOWN, LIVE, BOOST.
REQ-017 frame_cnt (10 bit) is loaded on entry to COOLDOWN/LIVE/BOOST with that state's parameter.
REQ-018 frame_cnt decrements by 1 on each CLK with frame_tick=1 and Pause=0.
REQ-019 "Expiry" = frame_cnt==1 with a counted tick; the state transition occurs on that same edge, so a state lasts exactly N counted ticks.
REQ-020 A parameter value of 0 SHALL be treated as 1.
REQ-021 IDLE: all outputs 0; game_active=1 -> COOLDOWN.
REQ-022 COOLDOWN: spawned=0; expiry -> LIVE.
REQ-023 On the COOLDOWN->LIVE edge, X/Y_Start and X/Y_Step latch from the LFSR and spawn_count increments.
REQ-024 X_Start = lfsr[8:0] + 40 (range 40..551).
REQ-025 Y_Start = lfsr[15:8] + 40 (range 40..295).
REQ-026 X_Step = lfsr[1:0] + 1; Y_Step = lfsr[3:2] + 1 (range 1..4 each).
REQ-027 Start/step outputs hold their latched values at all times except the spawn edge.
REQ-028 LIVE: spawned=1; StarBoost=1 -> BOOST; expiry -> COOLDOWN.
REQ-029 StarBoost=1 and expiry on the same edge -> BOOST (collection wins).
REQ-030 BOOST: spawned=0, boost_active=1; StarBoost is ignored; expiry -> COOLDOWN with boost_active=0.
REQ-031 game_active=0 in any state -> IDLE on the next edge; spawned and boost_active cleared; start/step/spawn_count held.
REQ-032 game_active 0->1 from IDLE SHALL clear spawn_count.
REQ-033 Pause=1 holds state and frame_cnt; StarBoost transitions out of LIVE remain enabled during Pause.
REQ-034 LFSR: 16-bit Fibonacci, taps 16,14,13,11, shift-left with feedback into bit 0; advances every CLK regardless of Pause or state.
REQ-035 All outputs registered; no combinational path from input to output.

Reset
REQ-036 RESET_N low SHALL immediately, without a clock, force: state IDLE, frame_cnt=0, lfsr=seed, all outputs 0.
REQ-037 Reset asserted mid-LIVE or mid-BOOST drops spawned/boost_active within the same cycle.
REQ-038 After RESET_N rises, the first state change requires a CLK edge.

Verification (COOLDOWN=3, LIFETIME=5, BOOST=4)
REQ-039 Reset release, game_active=1, 3 frame_ticks -> spawned=1 on the 3rd tick edge, spawn_count=1, X_Start in 40..551, X_Step in 1..4.
REQ-040 LIVE, no StarBoost, 5 ticks -> spawned=0, boost_active=0, COOLDOWN; after 3 more ticks spawn_count=2.
REQ-041 LIVE, StarBoost pulsed on the 5th-tick edge -> BOOST (not COOLDOWN); boost_active=1 for exactly 4 ticks, then 0.
REQ-042 COOLDOWN with Pause=1 over 10 ticks -> no spawn; Pause=0, then 3 ticks -> spawn.
REQ-043 RESET_N pulled low mid-BOOST with CLK stopped -> boost_active and spawned 0 immediately; spawn_count=0.
REQ-044 game_active dropped in LIVE -> IDLE next edge, spawned=0; reassert -> spawn_count restarts at 1 on the next spawn.

Source files
------------

// File: rtl/star_spawner_if.sv
// Bundles the frame/gameplay controls going into the star spawner and the
// spawn description coming back out of it.
interface star_spawner_if;
    logic       frame_tick;
    logic       Pause;
    logic       game_active;
    logic       StarBoost;
    logic       spawned;
    logic [9:0] X_Start;
    logic [9:0] Y_Start;
    logic [9:0] X_Step;
    logic [9:0] Y_Step;
    logic       boost_active;
    logic [7:0] spawn_count;

    // Game logic side: drives the frame/gameplay controls, consumes the spawn.
    modport master (
        output frame_tick,
        output Pause,
        output game_active,
        output StarBoost,
        input  spawned,
        input  X_Start,
        input  Y_Start,
        input  X_Step,
        input  Y_Step,
        input  boost_active,
        input  spawn_count
    );

    // Spawner side.
    modport slave (
        input  frame_tick,
        input  Pause,
        input  game_active,
        input  StarBoost,
        output spawned,
        output X_Start,
        output Y_Start,
        output X_Step,
        output Y_Step,
        output boost_active,
        output spawn_count
    );
endinterface

// File: rtl/star_spawner.sv
// Star spawner: alternates a cooldown, a live star with a finite lifetime and
// a boost window after collection. Spawn position and motion come from a
// free-running 16-bit LFSR. Every output is a flop.
module star_spawner #(
    parameter logic [9:0]  COOLDOWN_FRAMES = 10'd300,
    parameter logic [9:0]  LIFETIME_FRAMES = 10'd600,
    parameter logic [9:0]  BOOST_FRAMES    = 10'd480,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic         CLK,
    input  logic         RESET_N,
    star_spawner_if.slave bus
);

    // A zero duration would never expire, so it behaves as one frame.
    localparam logic [9:0]  CD_LOAD   = (COOLDOWN_FRAMES == 10'd0) ? 10'd1 : COOLDOWN_FRAMES;
    localparam logic [9:0]  LIFE_LOAD = (LIFETIME_FRAMES == 10'd0) ? 10'd1 : LIFETIME_FRAMES;
    localparam logic [9:0]  BST_LOAD  = (BOOST_FRAMES    == 10'd0) ? 10'd1 : BOOST_FRAMES;
    // An all-zero LFSR is a lock-up state.
    localparam logic [15:0] SEED_LOAD = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    localparam logic [9:0]  POS_OFFSET = 10'd40;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COOLDOWN = 2'd1,
        LIVE     = 2'd2,
        BOOST    = 2'd3
    } state_t;

    state_t      state_q,        state_d;
    logic [9:0]  frame_cnt_q,    frame_cnt_d;
    logic [15:0] lfsr_q,         lfsr_d;
    logic        spawned_q,      spawned_d;
    logic        boost_active_q, boost_active_d;
    logic [9:0]  x_start_q,      x_start_d;
    logic [9:0]  y_start_q,      y_start_d;
    logic [9:0]  x_step_q,       x_step_d;
    logic [9:0]  y_step_q,       y_step_d;
    logic [7:0]  spawn_count_q,  spawn_count_d;

    logic counted_tick;
    logic expiry;

    // A frame only counts when the game is not paused; expiry is the last
    // counted frame of the current state, so the state lasts exactly N frames.
    assign counted_tick = bus.frame_tick & ~bus.Pause;
    assign expiry       = counted_tick && (frame_cnt_q == 10'd1);

    // Fibonacci LFSR, taps 16/14/13/11, shifting left; runs every cycle.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // Next-state, frame counter, spawn latch and registered-output decode.
    always_comb begin
        state_d       = state_q;
        frame_cnt_d   = frame_cnt_q;
        x_start_d     = x_start_q;
        y_start_d     = y_start_q;
        x_step_d      = x_step_q;
        y_step_d      = y_step_q;
        spawn_count_d = spawn_count_q;

        if (counted_tick && (frame_cnt_q != 10'd0)) begin
            frame_cnt_d = frame_cnt_q - 10'd1;
        end

        if (!bus.game_active) begin
            // Leaving the round keeps the last spawn description and count.
            state_d     = IDLE;
            frame_cnt_d = 10'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A fresh round starts counting spawns from zero.
                    state_d       = COOLDOWN;
                    frame_cnt_d   = CD_LOAD;
                    spawn_count_d = 8'd0;
                end
                COOLDOWN: begin
                    if (expiry) begin
                        state_d       = LIVE;
                        frame_cnt_d   = LIFE_LOAD;
                        x_start_d     = {1'b0, lfsr_q[8:0]} + POS_OFFSET;
                        y_start_d     = {2'b00, lfsr_q[15:8]} + POS_OFFSET;
                        x_step_d      = {8'd0, lfsr_q[1:0]} + 10'd1;
                        y_step_d      = {8'd0, lfsr_q[3:2]} + 10'd1;
                        spawn_count_d = spawn_count_q + 8'd1;
                    end
                end
                LIVE: begin
                    // Collection beats a simultaneous timeout and is honoured
                    // even while paused.
                    if (bus.StarBoost) begin
                        state_d     = BOOST;
                        frame_cnt_d = BST_LOAD;
                    end else if (expiry) begin
                        state_d     = COOLDOWN;
                        frame_cnt_d = CD_LOAD;
                    end
                end
                BOOST: begin
                    if (expiry) begin
                        state_d     = COOLDOWN;
                        frame_cnt_d = CD_LOAD;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    frame_cnt_d = 10'd0;
                end
            endcase
        end

        // Status flags are decoded from the next state so they change on the
        // same edge as the state they describe.
        spawned_d      = (state_d == LIVE);
        boost_active_d = (state_d == BOOST);
    end

    // State and output registers with immediate asynchronous clear.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q        <= IDLE;
            frame_cnt_q    <= 10'd0;
            lfsr_q         <= SEED_LOAD;
            spawned_q      <= 1'b0;
            boost_active_q <= 1'b0;
            x_start_q      <= 10'd0;
            y_start_q      <= 10'd0;
            x_step_q       <= 10'd0;
            y_step_q       <= 10'd0;
            spawn_count_q  <= 8'd0;
        end else begin
            state_q        <= state_d;
            frame_cnt_q    <= frame_cnt_d;
            lfsr_q         <= lfsr_d;
            spawned_q      <= spawned_d;
            boost_active_q <= boost_active_d;
            x_start_q      <= x_start_d;
            y_start_q      <= y_start_d;
            x_step_q       <= x_step_d;
            y_step_q       <= y_step_d;
            spawn_count_q  <= spawn_count_d;
        end
    end

    assign bus.spawned      = spawned_q;
    assign bus.boost_active = boost_active_q;
    assign bus.X_Start      = x_start_q;
    assign bus.Y_Start      = y_start_q;
    assign bus.X_Step       = x_step_q;
    assign bus.Y_Step       = y_step_q;
    assign bus.spawn_count  = spawn_count_q;

endmodule

// File: tb/tb_star_spawner.sv
// Directed bench for star_spawner with short cooldown/lifetime/boost periods.
module tb_star_spawner;

    logic clk;
    logic clk_en;
    logic rst_n;

    star_spawner_if sif();

    star_spawner #(
        .COOLDOWN_FRAMES(10'd3),
        .LIFETIME_FRAMES(10'd5),
        .BOOST_FRAMES   (10'd4),
        .LFSR_SEED      (16'hACE1)
    ) dut (
        .CLK    (clk),
        .RESET_N(rst_n),
        .bus    (sif)
    );

    int passed = 0;
    int total  = 0;

    logic [15:0] lfsr_m;
    logic [15:0] lfsr_prev;
    logic [9:0]  held_x;
    logic [9:0]  held_y;

    // Gateable clock, parked low when stopped.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    // Reference LFSR; lfsr_prev is the value present before the latest edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_m    <= 16'hACE1;
            lfsr_prev <= 16'hACE1;
        end else begin
            lfsr_prev <= lfsr_m;
            lfsr_m    <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sif.frame_tick = 1'b1;
        @(posedge clk);
        #1;
        sif.frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Checks a freshly spawned star against the reference LFSR.
    task automatic check_spawn(input string tag, input logic [7:0] cnt);
        logic [9:0] ex;
        logic [9:0] ey;
        ex = {1'b0, lfsr_prev[8:0]} + 10'd40;
        ey = {2'b00, lfsr_prev[15:8]} + 10'd40;
        check({tag, "_spawned"}, sif.spawned, 1);
        check({tag, "_count"}, sif.spawn_count, cnt);
        check({tag, "_xstart"}, sif.X_Start, ex);
        check({tag, "_ystart"}, sif.Y_Start, ey);
        check({tag, "_xstep"}, sif.X_Step, {8'd0, lfsr_prev[1:0]} + 10'd1);
        check({tag, "_ystep"}, sif.Y_Step, {8'd0, lfsr_prev[3:2]} + 10'd1);
        check({tag, "_xrange"}, (sif.X_Start >= 10'd40 && sif.X_Start <= 10'd551), 1);
        check({tag, "_steprange"}, (sif.X_Step >= 10'd1 && sif.X_Step <= 10'd4), 1);
        held_x = ex;
        held_y = ey;
        $display("spawn %s: count=%0d X=%0d Y=%0d", tag, sif.spawn_count, sif.X_Start, sif.Y_Start);
    endtask

    initial begin
        clk_en          = 1'b1;
        rst_n           = 1'b0;
        sif.frame_tick  = 1'b0;
        sif.Pause       = 1'b0;
        sif.game_active = 1'b0;
        sif.StarBoost   = 1'b0;
        held_x          = 10'd0;
        held_y          = 10'd0;

        // Reset state.
        #12;
        check("rst_spawned", sif.spawned, 0);
        check("rst_boost", sif.boost_active, 0);
        check("rst_count", sif.spawn_count, 0);
        check("rst_xstart", sif.X_Start, 0);
        check("rst_ystep", sif.Y_Step, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sif.game_active = 1'b1;
        #1;
        check("release_no_clock", sif.spawned, 0);

        // First spawn: enter cooldown, then three counted frames.
        cycle();
        ticks(2);
        check("cd_not_yet", sif.spawned, 0);
        tick();
        check_spawn("spawn1", 8'd1);

        // Lifetime expiry without collection.
        ticks(4);
        check("live_4", sif.spawned, 1);
        check("live_hold_x", sif.X_Start, held_x);
        tick();
        check("expire_spawned", sif.spawned, 0);
        check("expire_boost", sif.boost_active, 0);
        ticks(2);
        check("cd2_not_yet", sif.spawned, 0);
        check("cd2_hold_y", sif.Y_Start, held_y);
        tick();
        check_spawn("spawn2", 8'd2);

        // Collection on the same edge as lifetime expiry wins.
        ticks(4);
        sif.StarBoost = 1'b1;
        tick();
        sif.StarBoost = 1'b0;
        check("collect_boost", sif.boost_active, 1);
        check("collect_spawned", sif.spawned, 0);
        sif.StarBoost = 1'b1;
        tick();
        sif.StarBoost = 1'b0;
        ticks(2);
        check("boost_3", sif.boost_active, 1);
        tick();
        check("boost_end", sif.boost_active, 0);
        check("boost_end_spawned", sif.spawned, 0);

        // Pause freezes the cooldown.
        sif.Pause = 1'b1;
        ticks(10);
        check("pause_no_spawn", sif.spawned, 0);
        sif.Pause = 1'b0;
        ticks(2);
        check("unpause_2", sif.spawned, 0);
        tick();
        check_spawn("spawn3", 8'd3);

        // Collection is still honoured while paused.
        sif.Pause     = 1'b1;
        sif.StarBoost = 1'b1;
        cycle();
        sif.Pause     = 1'b0;
        sif.StarBoost = 1'b0;
        check("pause_collect", sif.boost_active, 1);
        ticks(2);
        check("mid_boost", sif.boost_active, 1);

        // Asynchronous reset mid-boost with the clock stopped.
        @(negedge clk);
        clk_en = 1'b0;
        #20;
        rst_n = 1'b0;
        #1;
        check("async_boost", sif.boost_active, 0);
        check("async_spawned", sif.spawned, 0);
        check("async_count", sif.spawn_count, 0);
        check("async_xstart", sif.X_Start, 0);
        #5;
        rst_n = 1'b1;
        #5;
        check("async_release_idle", sif.spawned, 0);
        clk_en = 1'b1;

        // New round after reset, then drop and re-enter the round.
        cycle();
        ticks(3);
        check_spawn("spawn_r2", 8'd1);
        sif.game_active = 1'b0;
        cycle();
        check("drop_spawned", sif.spawned, 0);
        check("drop_count_held", sif.spawn_count, 1);
        check("drop_x_held", sif.X_Start, held_x);
        sif.game_active = 1'b1;
        cycle();
        check("rejoin_count_clear", sif.spawn_count, 0);
        ticks(3);
        check_spawn("spawn_r3", 8'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
